sync_fifo_param: RTL and testbench

Single-clock, fully parametrised FIFO. It is the next generation of the team's register-based FIFO. Additions: all DEPTH entries usable, an occupancy count, programmable almost-full/almost-empty thresholds, an optional first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It sits between same-clock producers and consumers, for example the command/pixel queue ahead of the display serialiser.

---
 rtl/sync_fifo_param.sv | 96 +++++++++
 tb/tb_sync_fifo_param.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost-full/empty
// thresholds, optional first-word-fall-through read, and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int BITS      = 8,
  parameter int DEPTH     = 32,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_enable,
  input  logic [BITS-1:0]        write_data,
  input  logic                   read_enable,
  output logic [BITS-1:0]        read_data,
  output logic                   read_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   clear_errors,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [BITS-1:0] mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic            write_acc;
  logic            read_acc;

  assign empty        = (level == '0);
  assign full         = (level == LW'(DEPTH));
  assign almost_empty = (level <= LW'(AE_THRESH));
  assign almost_full  = (level >= LW'(AF_THRESH));

  assign write_acc = write_enable && !full && !rst;
  assign read_acc  = read_enable && !empty && !rst;

  always_ff @(posedge clk) begin
    if (write_acc) begin
      mem[wptr[AW-1:0]] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_acc) wptr <= wptr + 1'b1;
      if (read_acc)  rptr <= rptr + 1'b1;
      if (write_acc && !read_acc)      level <= level + 1'b1;
      else if (read_acc && !write_acc) level <= level - 1'b1;
      // a new error in the same cycle as clear_errors keeps the flag set
      if (write_enable && full)     overflow <= 1'b1;
      else if (clear_errors)        overflow <= 1'b0;
      if (read_enable && empty)     underflow <= 1'b1;
      else if (clear_errors)        underflow <= 1'b0;
    end
  end

  // the pointer distance (modulo 2*DEPTH) must always agree with the level counter
  always_comb begin
    ptr_consistent: assert (level == (wptr - rptr));
  end

  if (FWFT != 0) begin : g_fwft
    assign read_data  = mem[rptr[AW-1:0]];
    assign read_valid = !empty;
  end else begin : g_std
    logic [BITS-1:0] data_q;
    logic            valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= read_acc;
        if (read_acc) data_q <= mem[rptr[AW-1:0]];
      end
    end

    assign read_data  = data_q;
    assign read_valid = valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param; a standard-read and an FWFT
// instance share one stimulus stream and one queue-based reference model.
module tb_sync_fifo_param;

  localparam int BITS  = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            write_enable = 1'b0;
  logic [BITS-1:0] write_data = '0;
  logic            read_enable = 1'b0;
  logic            clear_errors = 1'b0;

  logic [BITS-1:0] rd_s, rd_f;
  logic            rv_s, rv_f, em_s, em_f, fu_s, fu_f, ae_s, ae_f, af_s, af_f;
  logic            ov_s, ov_f, un_s, un_f;
  logic [3:0]      lv_s, lv_f;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // reference model state
  logic [BITS-1:0] q[$];
  logic [BITS-1:0] m_rd;
  logic            m_rv, m_ov, m_un;

  always #5 clk = ~clk;

  sync_fifo_param #(.BITS(BITS), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut_std (
    .clk(clk), .rst(rst), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(rd_s), .read_valid(rv_s), .empty(em_s),
    .full(fu_s), .almost_empty(ae_s), .almost_full(af_s), .level(lv_s),
    .clear_errors(clear_errors), .overflow(ov_s), .underflow(un_s));

  sync_fifo_param #(.BITS(BITS), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_fwft (
    .clk(clk), .rst(rst), .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(rd_f), .read_valid(rv_f), .empty(em_f),
    .full(fu_f), .almost_empty(ae_f), .almost_full(af_f), .level(lv_f),
    .clear_errors(clear_errors), .overflow(ov_f), .underflow(un_f));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = q.size();
    check("level",     32'(lv_s), n);
    check("empty",     32'(em_s), 32'(n == 0));
    check("full",      32'(fu_s), 32'(n == DEPTH));
    check("alm_empty", 32'(ae_s), 32'(n <= AE));
    check("alm_full",  32'(af_s), 32'(n >= AF));
    check("rdata",     32'(rd_s), 32'(m_rd));
    check("rvalid",    32'(rv_s), 32'(m_rv));
    check("overflow",  32'(ov_s), 32'(m_ov));
    check("underflow", 32'(un_s), 32'(m_un));
    check("f_level",   32'(lv_f), n);
    check("f_rvalid",  32'(rv_f), 32'(n != 0));
    check("f_oflow",   32'(ov_f), 32'(m_ov));
    check("f_uflow",   32'(un_f), 32'(m_un));
    if (n != 0) check("f_rdata", 32'(rd_f), 32'(q[0]));
  endtask

  // one clock: apply inputs, advance the model by the FIFO rules, then compare
  task automatic step(input logic we, input logic [BITS-1:0] wd, input logic re,
                      input logic ce, input logic r);
    logic was_full, was_empty;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    clear_errors = ce;
    rst          = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rd = '0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_rv = re && !was_empty;
      if (m_rv) m_rd = q.pop_front();
      if (we && !was_full) q.push_back(wd);
      if (we && was_full) m_ov = 1'b1; else if (ce) m_ov = 1'b0;
      if (re && was_empty) m_un = 1'b1; else if (ce) m_un = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    m_rd = '0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // fill, overflow attempt, drain, underflow attempt, clear
    for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("hold_08", 32'(rd_s), 32'h08);
    step(0, 8'h00, 0, 1, 0);

    // steady simultaneous traffic at level 4
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h20 + i), 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
    step(1, 8'hBB, 1, 0, 0);
    check("full_rw_lv", 32'(lv_s), 32'd7);
    for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 1, 0);
    step(1, 8'hCC, 1, 0, 0);
    check("empty_rw_lv", 32'(lv_s), 32'd1);
    step(0, 8'h00, 1, 1, 0);

    // pointer wrap-around with write/read pairs; FWFT head visible next cycle
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h40 + i), 0, 0, 0);
      check("fwft_head", 32'(rd_f), 32'(8'h40 + i));
      step(0, 8'h00, 1, 0, 0);
    end
    step(1, 8'h5A, 0, 0, 0);
    check("fwft_5a", 32'(rd_f), 32'h5A);
    step(0, 8'h00, 1, 0, 0);
    check("fwft_pop_rv", 32'(rv_f), 32'd0);

    // reset mid-stream at level 5 together with a write
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 1);
    check("rst_level", 32'(lv_s), 32'd0);
    step(1, 8'h77, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("rst_newdata", 32'(rd_s), 32'h77);

    // random traffic with occasional resets and error clears
    for (int i = 0; i < 3000; i++) begin
      int unsigned bias;
      bias = (i / 300) % 3;
      step(($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
           8'($urandom), ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
